mem_ctrl_requester: RTL

//  Initiator side of the mem/rw/burst memory-controller protocol. Accepts one

---
 rtl/mem_ctrl_requester.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_ctrl_requester.sv
// mem_ctrl_requester: initiator side of the mem/rw/burst memory-controller
// handshake. One command in flight at a time; every output is a flop.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | ready for a command; stray oe/we flags err
// S_REQ   | one-cycle mem pulse with direction, burst held low
// S_RDATA | waiting for oe beats (1 or 4), burst held from the command
// S_WDATA | addr/wdata presented, waiting for a single we
module mem_ctrl_requester #(
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int TIMEOUT = 15
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_cmd_valid,
    output logic          o_cmd_ready,
    input  logic          i_cmd_rw,
    input  logic          i_cmd_burst,
    input  logic [AW-1:0] i_cmd_addr,
    input  logic [DW-1:0] i_cmd_wdata,
    output logic          o_mem,
    output logic          o_rw,
    output logic          o_burst,
    input  logic          i_oe,
    input  logic          i_we,
    output logic [AW-1:0] o_addr,
    output logic [DW-1:0] o_wdata,
    input  logic [DW-1:0] i_rdata,
    output logic          o_rsp_valid,
    output logic [DW-1:0] o_rsp_data,
    output logic          o_rsp_last,
    output logic          o_busy,
    output logic          o_err
);

    localparam int TW = 8;
    localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_RDATA = 2'd2,
        S_WDATA = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic          r_rw;
    logic          r_burst;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [2:0]    r_beats;
    logic [TW-1:0] r_timer;
    logic [DW-1:0] r_rsp_data;

    logic          w_rw_nxt;
    logic          w_burst_nxt;
    logic [AW-1:0] w_addr_nxt;
    logic [DW-1:0] w_wdata_nxt;
    logic [2:0]    w_beats_nxt;
    logic [TW-1:0] w_timer_nxt;
    logic [DW-1:0] w_rsp_data_nxt;
    logic          w_rsp_valid_nxt;
    logic          w_rsp_last_nxt;
    logic          w_err_nxt;
    logic          w_handshake;

    assign w_handshake = i_cmd_valid & o_cmd_ready;
    assign o_addr      = r_addr;
    assign o_wdata     = r_wdata;
    assign o_rsp_data  = r_rsp_data;

    // State register.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next-output decode. The timer is a down-counter reloaded
    // on every accepted strobe; hitting 1 on a strobe-less cycle is the
    // TIMEOUT-th idle cycle and ends the transaction.
    always_comb begin
        w_state_nxt     = r_state;
        w_rw_nxt        = r_rw;
        w_burst_nxt     = r_burst;
        w_addr_nxt      = r_addr;
        w_wdata_nxt     = r_wdata;
        w_beats_nxt     = r_beats;
        w_timer_nxt     = r_timer;
        w_rsp_data_nxt  = r_rsp_data;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_last_nxt  = 1'b0;
        w_err_nxt       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_oe || i_we) begin
                    w_err_nxt = 1'b1;
                end else if (w_handshake) begin
                    w_rw_nxt    = i_cmd_rw;
                    w_burst_nxt = i_cmd_burst & i_cmd_rw;
                    w_addr_nxt  = i_cmd_addr;
                    w_wdata_nxt = i_cmd_wdata;
                    w_beats_nxt = (i_cmd_burst & i_cmd_rw) ? 3'd4 : 3'd1;
                    w_timer_nxt = TIMER_LOAD;
                    w_state_nxt = S_REQ;
                end
            end

            S_REQ: begin
                if (i_oe || i_we) begin
                    w_err_nxt   = 1'b1;
                    w_beats_nxt = 3'd0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_timer_nxt = TIMER_LOAD;
                    w_state_nxt = r_rw ? S_RDATA : S_WDATA;
                end
            end

            S_RDATA: begin
                if (i_we) begin
                    w_err_nxt   = 1'b1;
                    w_beats_nxt = 3'd0;
                    w_state_nxt = S_IDLE;
                end else if (i_oe) begin
                    w_rsp_data_nxt  = i_rdata;
                    w_rsp_valid_nxt = 1'b1;
                    w_addr_nxt      = r_addr + AW'(1);
                    w_beats_nxt     = r_beats - 3'd1;
                    w_timer_nxt     = TIMER_LOAD;
                    if (r_beats == 3'd1) begin
                        w_rsp_last_nxt = 1'b1;
                        w_state_nxt    = S_IDLE;
                    end
                end else if (r_timer == TW'(1)) begin
                    w_err_nxt   = 1'b1;
                    w_beats_nxt = 3'd0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_timer_nxt = r_timer - TW'(1);
                end
            end

            S_WDATA: begin
                if (i_oe) begin
                    w_err_nxt   = 1'b1;
                    w_beats_nxt = 3'd0;
                    w_state_nxt = S_IDLE;
                end else if (i_we) begin
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_last_nxt  = 1'b1;
                    w_beats_nxt     = 3'd0;
                    w_state_nxt     = S_IDLE;
                end else if (r_timer == TW'(1)) begin
                    w_err_nxt   = 1'b1;
                    w_beats_nxt = 3'd0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_timer_nxt = r_timer - TW'(1);
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath and registered outputs; controller-facing strobes are decoded
    // from the next state so they line up with the state they describe.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_rw        <= 1'b0;
            r_burst     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_beats     <= 3'd0;
            r_timer     <= '0;
            r_rsp_data  <= '0;
            o_rsp_valid <= 1'b0;
            o_rsp_last  <= 1'b0;
            o_err       <= 1'b0;
            o_mem       <= 1'b0;
            o_rw        <= 1'b0;
            o_burst     <= 1'b0;
            o_cmd_ready <= 1'b1;
            o_busy      <= 1'b0;
        end else begin
            r_rw        <= w_rw_nxt;
            r_burst     <= w_burst_nxt;
            r_addr      <= w_addr_nxt;
            r_wdata     <= w_wdata_nxt;
            r_beats     <= w_beats_nxt;
            r_timer     <= w_timer_nxt;
            r_rsp_data  <= w_rsp_data_nxt;
            o_rsp_valid <= w_rsp_valid_nxt;
            o_rsp_last  <= w_rsp_last_nxt;
            o_err       <= w_err_nxt;
            o_mem       <= (w_state_nxt == S_REQ);
            o_rw        <= (w_state_nxt != S_IDLE) & w_rw_nxt;
            o_burst     <= (w_state_nxt == S_RDATA) & w_burst_nxt;
            o_cmd_ready <= (w_state_nxt == S_IDLE);
            o_busy      <= (w_state_nxt != S_IDLE);
        end
    end

endmodule
